// File: rtl/sram_pkg.sv
// Shared constants for the 1024x18 dual-port SRAM macro and its port controllers.
package sram_pkg;

  localparam int unsigned SRAM_AW = 10;
  localparam int unsigned SRAM_DW = 18;

  localparam logic SRAM_MASK_KEEP = 1'b1;
  localparam logic SRAM_EN_ACTIVE = 1'b0;

endpackage : sram_pkg

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO: DW x DEPTH storage, count-based full/empty, pointers wrap modulo DEPTH.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int unsigned DW    = SRAM_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so push while full is legal then.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule : sram_rsp_fifo

// File: rtl/sram_port_initiator.sv
// Drives one SRAM port from a valid/ready request stream and returns read data
// in order through a credit-limited response FIFO.
module sram_port_initiator
  import sram_pkg::*;
#(
  parameter int unsigned AW        = SRAM_AW,
  parameter int unsigned DW        = SRAM_DW,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DW-1:0] req_bwe,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wmsk,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  logic          ready_en;
  logic          p1;
  logic          p2;
  logic          accept;
  logic          accept_rd;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;

  // Every read holds a credit from accept until its response is popped.
  assign inflight  = CW'(p1) + CW'(p2) + fifo_count;
  assign req_ready = ready_en & ~(~req_we & (inflight >= CW'(RSP_DEPTH)));
  assign accept    = req_valid & req_ready;
  assign accept_rd = accept & ~req_we;

  assign rsp_valid = ~fifo_empty;
  assign fifo_pop  = rsp_valid & rsp_ready;
  assign busy      = p1 | p2 | ~fifo_empty;

  // Issue flops and read-pipeline valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      p1         <= 1'b0;
      p2         <= 1'b0;
      sram_cen   <= ~SRAM_EN_ACTIVE;
      sram_wen   <= ~SRAM_EN_ACTIVE;
      sram_addr  <= '0;
      sram_wmsk  <= '0;
      sram_wdata <= '0;
    end else begin
      ready_en <= 1'b1;
      p1       <= accept_rd;
      p2       <= p1;
      if (accept) begin
        sram_cen  <= SRAM_EN_ACTIVE;
        sram_addr <= req_addr;
        if (req_we) begin
          sram_wen   <= SRAM_EN_ACTIVE;
          sram_wmsk  <= ~req_bwe;
          sram_wdata <= req_wdata;
        end else begin
          sram_wen  <= ~SRAM_EN_ACTIVE;
          sram_wmsk <= {DW{SRAM_MASK_KEEP}};
        end
      end else begin
        sram_cen <= ~SRAM_EN_ACTIVE;
        sram_wen <= ~SRAM_EN_ACTIVE;
      end
    end
  end

  sram_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (p2),
    .wdata (sram_rdata),
    .pop   (fifo_pop),
    .rdata (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The credit rule must never let a response arrive at a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(p2 && fifo_full && !fifo_pop));

endmodule : sram_port_initiator

// File: tb/tb_sram_port_initiator.sv
// Bench: initiator plus a behavioural SRAM port; read responses are scored
// against an in-order memory model updated at request acceptance.
module tb_sram_port_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [17:0] req_wdata;
  logic [17:0] req_bwe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [17:0] rsp_rdata;
  logic        sram_cen;
  logic        sram_wen;
  logic [9:0]  sram_addr;
  logic [17:0] sram_wmsk;
  logic [17:0] sram_wdata;
  logic [17:0] sram_rdata;
  logic        busy;

  always #5 clk = ~clk;

  sram_port_initiator #(.AW(10), .DW(18), .RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_bwe    (req_bwe),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wmsk  (sram_wmsk),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  // Synchronous SRAM port: one-cycle read, wmsk bit 1 keeps the stored bit.
  logic [17:0] sram_mem [1024];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen)
        sram_mem[sram_addr] <= (sram_mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
      else
        sram_rdata <= sram_mem[sram_addr];
    end
  end

  logic [17:0] ref_mem [1024];
  logic [17:0] exp_q [$];
  logic [17:0] last_rdata;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: requests take effect in acceptance order; reads return current contents.
  task automatic model_accept(input logic we, input logic [9:0] a, input logic [17:0] d,
                              input logic [17:0] bwe);
    if (we) ref_mem[a] = (ref_mem[a] & ~bwe) | (d & bwe);
    else    exp_q.push_back(ref_mem[a]);
  endtask

  task automatic drive(input logic we, input logic [9:0] a, input logic [17:0] d,
                       input logic [17:0] bwe);
    req_we = we; req_addr = a; req_wdata = d; req_bwe = bwe; req_valid = 1'b1;
  endtask

  task automatic do_req(input logic we, input logic [9:0] a, input logic [17:0] d,
                        input logic [17:0] bwe);
    int n;
    drive(we, a, d, bwe);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    if (req_ready) model_accept(we, a, d, bwe);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic try_req(input logic we, input logic [9:0] a, input logic [17:0] d,
                         input logic [17:0] bwe, output logic acc);
    drive(we, a, d, bwe);
    @(negedge clk);
    acc = req_ready;
    if (acc) model_accept(we, a, d, bwe);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every handshaken response must match the oldest expected read.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        last_rdata = rsp_rdata;
      end
    end
  end

  initial begin
    logic acc;
    int   n_acc;
    int   n_rsp;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_bwe = '0; rsp_ready = 1'b1; last_rdata = '0;

    #12;
    check("rst_cen", 32'(sram_cen), 32'd1);
    check("rst_wen", 32'(sram_wen), 32'd1);
    check("rst_addr_wmsk_wdata", {sram_addr, sram_wmsk, sram_wdata[3:0]}, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ready_before_first_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", 32'(req_ready), 32'd1);

    // Write then read with 2-cycle response latency.
    do_req(1'b1, 10'h005, 18'h2AAAA, 18'h3FFFF);
    do_req(1'b0, 10'h005, 18'h0, 18'h0);
    @(negedge clk); check("lat_after_e0", 32'(rsp_valid), 32'd0);
    @(negedge clk); check("lat_after_e1", 32'(rsp_valid), 32'd0);
    @(negedge clk); check("lat_after_e2", 32'(rsp_valid), 32'd1);
    drain();
    check("t1_data", 32'(last_rdata), 32'h2AAAA);

    // Partial write keeps unmasked bits.
    do_req(1'b1, 10'h010, 18'h3FFFF, 18'h3FFFF);
    do_req(1'b1, 10'h010, 18'h00000, 18'h000FF);
    do_req(1'b0, 10'h010, 18'h0, 18'h0);
    drain();
    check("t2_masked", 32'(last_rdata), 32'h3FF00);

    // Top address, read immediately after write.
    do_req(1'b1, 10'h3FF, 18'h12345, 18'h3FFFF);
    do_req(1'b0, 10'h3FF, 18'h0, 18'h0);
    drain();
    check("t4_top_addr", 32'(last_rdata), 32'h12345);

    // Back-pressure: credit limit of 4 reads, writes still pass.
    for (int i = 0; i < 6; i++) do_req(1'b1, 10'(10'h100 + i), 18'(18'h1000 + 18'(i * 37)), 18'h3FFFF);
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_req(1'b0, 10'(10'h100 + i), 18'h0, 18'h0, acc);
      if (acc) n_acc++;
    end
    check("t3_reads_accepted", 32'(n_acc), 32'd4);
    try_req(1'b0, 10'h104, 18'h0, 18'h0, acc);
    check("t3_read_blocked", 32'(acc), 32'd0);
    try_req(1'b1, 10'h200, 18'h0ABCD, 18'h3FFFF, acc);
    check("t3_write_accepted", 32'(acc), 32'd1);
    check("t3_busy_full", 32'(busy), 32'd1);
    drain();
    check("t3_last", 32'(last_rdata), 32'h1000 + 32'd111);

    // Reset with two reads in flight and one buffered.
    rsp_ready = 1'b0;
    do_req(1'b0, 10'h005, 18'h0, 18'h0);
    do_req(1'b0, 10'h010, 18'h0, 18'h0);
    do_req(1'b0, 10'h3FF, 18'h0, 18'h0);
    check("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_cen_in_reset", 32'(sram_cen), 32'd1);
    check("t5_rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("t5_no_rsp_after_reset", 32'(n_rsp), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Random mix on a small address window plus the top word.
    for (int i = 0; i < 10000; i++) begin
      logic [9:0] a;
      rsp_ready = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), a, 18'($urandom), 18'($urandom));
      req_valid = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (req_valid && req_ready) model_accept(req_we, req_addr, req_wdata, req_bwe);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sram_port_initiator
